sd_block_arbiter: RTL and testbench
===================================

Name: sd_block_arbiter

Overview:
Shares the single SD card controller between two block-level requesters (e.g. a loader and a logger). It grants one requester at a time using round-robin, drives the controller's op_code/execute/block_address, and routes the per-byte strobes and data in both directions. It reports completion per transaction, and raises a timeout error if the controller stalls.

Parameters:
TIMEOUT_CYCLES, 24'd4000000, clk cycles allowed from execute to sd_finished_block before the transaction is aborted with error.
ISSUE_HOLD, 4'd8, max clk cycles execute is held while waiting for sd_busy to rise.

Ports:
clk  input  1  master clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
req  input  2  per-requester transaction request, level, held until done
req_op  input  2  per-requester op: 0 READ, 1 WRITE
req_addr  input  64  {addr1, addr0}, 32-bit block address each
req_wr_byte  input  16  {byte1, byte0}, write data from each requester
grant  output  2  one-hot owner of the controller, 0 when idle
byte_strobe  output  2  one-cycle pulse to the owner per transferred byte
rd_byte  output  8  read data, valid with byte_strobe
done  output  2  one-cycle pulse to the owner at end of transaction
error  output  2  one-cycle pulse with done on timeout
byte_count  output  10  bytes transferred in current/last transaction
sd_op_code  output  1  to controller op_code
sd_execute  output  1  to controller execute
sd_block_address  output  32  to controller block_address
sd_outgoing_byte  output  8  to controller outgoing_byte
sd_busy  input  1  controller busy
sd_finished_byte  input  1  controller byte pulse
sd_finished_block  input  1  controller block pulse
sd_incoming_byte  input  8  controller read byte

Behaviour:
- Reset values: grant=0, byte_strobe=0, done=0, error=0, byte_count=0, sd_execute=0, sd_op_code=0, sd_block_address=0, rd_byte=0. The round-robin pointer resets to requester 0. State resets to IDLE.
- sd_finished_byte and sd_finished_block are synchronised through 2 flops. Each is rising-edge detected. All "pulse" references below mean the detected edge.
- IDLE: if any req bit is set and sd_busy=0, select the winner. The winner is the requester at the pointer if it is requesting, else the other one. Latch its op and addr into sd_op_code/sd_block_address. Set the grant bit, clear byte_count, go to ISSUE. If sd_busy=1 (card still initialising), stay in IDLE.
- ISSUE: sd_execute=1. On sd_busy=1, drop sd_execute and go to XFER. If ISSUE_HOLD cycles elapse without sd_busy, drop sd_execute and go to COMPLETE with error.
- XFER: on each byte pulse:
  - byte_strobe[owner] pulses 1 cycle.
  - byte_count increments, saturating at 1023.
  - On READ, rd_byte captures sd_incoming_byte in the same cycle.
- sd_outgoing_byte always combinationally mirrors req_wr_byte of the owner. The owner must present the next byte within 1 cycle after byte_strobe.
- On a block pulse, go to COMPLETE without error. If byte and block pulses coincide, both are processed in that cycle: the strobe and count update happen, then COMPLETE.
- Timeout counter starts on entry to ISSUE. At TIMEOUT_CYCLES it forces COMPLETE with error.
- COMPLETE:
  - done[owner] pulses 1 cycle, with error[owner] if flagged.
  - grant clears.
  - The pointer moves to the other requester.
  - Go to WAIT_IDLE.
- WAIT_IDLE: wait for sd_busy=0, then go to IDLE. This guarantees a fresh execute is not issued while the controller is still busy.
- Owner dropping req mid-transaction is ignored: the transaction runs to completion and done still pulses.
- Requests while not in IDLE are held off. Grant changes only in IDLE and COMPLETE.
- An rst_n assertion mid-transaction returns the block to IDLE immediately with all outputs at reset values. No done is issued.

Test Plan:
1. Only req[0]=1, READ, addr0=32'h00000010. The controller model gives busy, 512 byte pulses with data 0..255,0..255, and a block pulse on the last byte. Required response:
   - sd_block_address=32'h10, sd_op_code=0.
   - 512 byte_strobe[0] pulses, with rd_byte matching the model.
   - byte_count=512, then done[0]=1, error=0.
2. req[1]=1, WRITE, with the requester counting req_wr_byte 0,1,2... on each strobe. Required response: the model samples sd_outgoing_byte 0..511 mod 256, the block pulse leads to done[1], and grant returns to 0.
3. req=2'b11 held across three transactions. Required response: grant sequence 01, 10, 01.
4. sd_busy held high after reset for 1000 cycles with req[0]=1. Required response: grant stays 0 and sd_execute=0 until busy falls; then the grant issues.
5. TIMEOUT_CYCLES=100 with the model never pulsing the block signal. Required response: done[0] and error[0] pulse together 100 cycles after ISSUE entry, then recovery to IDLE.
6. rst_n pulled low at byte 200 of a read. Required response: all outputs zero, no done pulse; after release, a new req[1] is granted first (pointer reset to 0, req[0] low).

Source files
------------

// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter that shares one SD card controller between two
// block-level requesters. Issues execute, routes byte strobes and data,
// reports per-transaction completion and aborts stalled transactions.
module sd_block_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
  parameter logic [3:0]  ISSUE_HOLD     = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_addr,
  input  logic [15:0] req_wr_byte,
  output logic [1:0]  grant,
  output logic [1:0]  byte_strobe,
  output logic [7:0]  rd_byte,
  output logic [1:0]  done,
  output logic [1:0]  error,
  output logic [9:0]  byte_count,
  output logic        sd_op_code,
  output logic        sd_execute,
  output logic [31:0] sd_block_address,
  output logic [7:0]  sd_outgoing_byte,
  input  logic        sd_busy,
  input  logic        sd_finished_byte,
  input  logic        sd_finished_block,
  input  logic [7:0]  sd_incoming_byte
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] XFER      = 3'd2;
  localparam logic [2:0] COMPLETE  = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic [2:0]  state;
  logic        owner;
  logic        ptr;
  logic        err_flag;
  logic [23:0] tmo_cnt;
  logic [3:0]  hold_cnt;
  logic [1:0]  fb_sync;
  logic [1:0]  fk_sync;
  logic        fb_prev;
  logic        fk_prev;
  logic        byte_pulse;
  logic        block_pulse;
  logic        winner;
  logic        tmo_hit;

  // Two-flop synchronisers plus a history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_sync <= '0;
      fk_sync <= '0;
      fb_prev <= 1'b0;
      fk_prev <= 1'b0;
    end else begin
      fb_sync <= {fb_sync[0], sd_finished_byte};
      fk_sync <= {fk_sync[0], sd_finished_block};
      fb_prev <= fb_sync[1];
      fk_prev <= fk_sync[1];
    end
  end

  // Edge pulses, round-robin winner selection and timeout detection
  always_comb begin
    byte_pulse  = fb_sync[1] & ~fb_prev;
    block_pulse = fk_sync[1] & ~fk_prev;
    winner      = req[ptr] ? ptr : ~ptr;
    tmo_hit     = (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
  end

  // done/error are decoded from COMPLETE so they land in the same cycle the
  // state is entered, keeping the timeout exactly TIMEOUT_CYCLES after ISSUE
  assign done             = (state == COMPLETE) ? grant : 2'b00;
  assign error            = done & {2{err_flag}};
  assign sd_outgoing_byte = owner ? req_wr_byte[15:8] : req_wr_byte[7:0];

  // Transaction sequencing: grant, issue, transfer, complete, drain busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      owner            <= 1'b0;
      ptr              <= 1'b0;
      err_flag         <= 1'b0;
      tmo_cnt          <= '0;
      hold_cnt         <= '0;
      grant            <= '0;
      byte_strobe      <= '0;
      rd_byte          <= '0;
      byte_count       <= '0;
      sd_op_code       <= 1'b0;
      sd_execute       <= 1'b0;
      sd_block_address <= '0;
    end else begin
      byte_strobe <= '0;
      case (state)
        IDLE: begin
          if ((|req) && !sd_busy) begin
            owner            <= winner;
            sd_op_code       <= req_op[winner];
            sd_block_address <= winner ? req_addr[63:32] : req_addr[31:0];
            grant            <= winner ? 2'b10 : 2'b01;
            byte_count       <= '0;
            tmo_cnt          <= '0;
            hold_cnt         <= '0;
            err_flag         <= 1'b0;
            sd_execute       <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= tmo_cnt + 24'd1;
          if (tmo_hit) begin
            sd_execute <= 1'b0;
            err_flag   <= 1'b1;
            state      <= COMPLETE;
          end else if (sd_busy) begin
            sd_execute <= 1'b0;
            state      <= XFER;
          end else if (hold_cnt == ISSUE_HOLD - 4'd1) begin
            sd_execute <= 1'b0;
            err_flag   <= 1'b1;
            state      <= COMPLETE;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        XFER: begin
          tmo_cnt <= tmo_cnt + 24'd1;
          if (byte_pulse) begin
            byte_strobe <= grant;
            if (byte_count != 10'd1023) byte_count <= byte_count + 10'd1;
            if (!sd_op_code) rd_byte <= sd_incoming_byte;
          end
          if (block_pulse) begin
            state <= COMPLETE;
          end else if (tmo_hit) begin
            err_flag <= 1'b1;
            state    <= COMPLETE;
          end
        end
        COMPLETE: begin
          grant <= '0;
          ptr   <= ~owner;
          state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (!sd_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed bench for sd_block_arbiter with a cycle-stepped controller model.
module tb_sd_block_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  req_op;
  logic [63:0] req_addr;
  logic [15:0] req_wr_byte;
  logic [1:0]  grant;
  logic [1:0]  byte_strobe;
  logic [7:0]  rd_byte;
  logic [1:0]  done;
  logic [1:0]  error;
  logic [9:0]  byte_count;
  logic        sd_op_code;
  logic        sd_execute;
  logic [31:0] sd_block_address;
  logic [7:0]  sd_outgoing_byte;
  logic        sd_busy;
  logic        sd_finished_byte;
  logic        sd_finished_block;
  logic [7:0]  sd_incoming_byte;

  // short-timeout instance
  logic [1:0]  req_t;
  logic        busy_t;
  logic [1:0]  t_op;
  logic [63:0] t_addr;
  logic [15:0] t_wr;
  logic        t_fb;
  logic        t_fk;
  logic [7:0]  t_in;
  logic [1:0]  grant_t;
  logic [1:0]  strobe_t;
  logic [7:0]  rd_byte_t;
  logic [1:0]  done_t;
  logic [1:0]  error_t;
  logic [9:0]  count_t;
  logic        op_t;
  logic        exec_t;
  logic [31:0] addr_t;
  logic [7:0]  out_t;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned strobes;
  int unsigned rd_errs;
  int unsigned wr_errs;
  logic [1:0]  done_seen;
  logic [1:0]  err_seen;
  logic [1:0]  strobe_or;
  logic [9:0]  cnt_at_done;
  logic [1:0]  gnt_at_exec;
  bit          txn_read;
  bit          exec_ok;
  logic [1:0]  gseq [3];

  sd_block_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_wr_byte(req_wr_byte), .grant(grant), .byte_strobe(byte_strobe),
    .rd_byte(rd_byte), .done(done), .error(error), .byte_count(byte_count),
    .sd_op_code(sd_op_code), .sd_execute(sd_execute),
    .sd_block_address(sd_block_address), .sd_outgoing_byte(sd_outgoing_byte),
    .sd_busy(sd_busy), .sd_finished_byte(sd_finished_byte),
    .sd_finished_block(sd_finished_block), .sd_incoming_byte(sd_incoming_byte)
  );

  sd_block_arbiter #(.TIMEOUT_CYCLES(24'd100), .ISSUE_HOLD(4'd8)) dut_t (
    .clk(clk), .rst_n(rst_n), .req(req_t), .req_op(t_op), .req_addr(t_addr),
    .req_wr_byte(t_wr), .grant(grant_t), .byte_strobe(strobe_t),
    .rd_byte(rd_byte_t), .done(done_t), .error(error_t), .byte_count(count_t),
    .sd_op_code(op_t), .sd_execute(exec_t),
    .sd_block_address(addr_t), .sd_outgoing_byte(out_t),
    .sd_busy(busy_t), .sd_finished_byte(t_fb),
    .sd_finished_block(t_fk), .sd_incoming_byte(t_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: step to the negedge, observe strobes/done, act as requester
  task automatic tick();
    @(negedge clk);
    if (byte_strobe != 2'b00) begin
      strobe_or |= byte_strobe;
      if (txn_read && rd_byte !== strobes[7:0]) rd_errs++;
      strobes++;
      if (byte_strobe[1]) req_wr_byte[15:8] = strobes[7:0];
      else                req_wr_byte[7:0]  = strobes[7:0];
    end
    if (done != 2'b00) begin
      done_seen  |= done;
      err_seen   |= error;
      cnt_at_done = byte_count;
    end
  endtask

  // Controller model: busy on execute, byte pulses every 8 cycles carrying
  // i mod 256, optional block pulse on the last byte, busy drops after done
  task automatic run_txn(input int unsigned nbytes, input bit is_read, input bit send_block);
    strobes = 0; rd_errs = 0; wr_errs = 0;
    done_seen = '0; err_seen = '0; strobe_or = '0; cnt_at_done = '0;
    txn_read = is_read; req_wr_byte = '0; exec_ok = 0; gnt_at_exec = '0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (sd_execute) begin exec_ok = 1; break; end
    end
    check_eq("exec_seen", {63'd0, exec_ok}, 64'd1);
    if (!exec_ok) return;
    gnt_at_exec = grant;
    sd_busy = 1'b1;
    for (int i = 0; i < int'(nbytes); i++) begin
      tick();
      if (!is_read && sd_outgoing_byte !== i[7:0]) wr_errs++;
      sd_incoming_byte = i[7:0];
      sd_finished_byte = 1'b1;
      if (send_block && i == int'(nbytes) - 1) sd_finished_block = 1'b1;
      tick();
      sd_finished_byte  = 1'b0;
      sd_finished_block = 1'b0;
      repeat (6) tick();
    end
    if (send_block) begin
      for (int k = 0; k < 30 && done_seen == 2'b00; k++) tick();
      sd_busy = 1'b0;
    end
  endtask

  initial begin
    int unsigned c;
    bit          found;
    bit          held;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; req = '0; req_op = '0; req_addr = '0; req_wr_byte = '0;
    sd_busy = 1'b0; sd_finished_byte = 1'b0; sd_finished_block = 1'b0; sd_incoming_byte = '0;
    req_t = '0; busy_t = 1'b0; t_op = '0; t_addr = '0; t_wr = '0; t_fb = 1'b0; t_fk = 1'b0; t_in = '0;
    strobes = 0; rd_errs = 0; wr_errs = 0; done_seen = '0; err_seen = '0; strobe_or = '0;
    cnt_at_done = '0; txn_read = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", {44'd0, grant, byte_strobe, done, error, byte_count, sd_execute, sd_op_code}, 64'd0);
    check_eq("reset_data", {24'd0, sd_block_address, rd_byte}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single READ from requester 0
    req_addr[31:0] = 32'h0000_0010; req_op = 2'b00; req = 2'b01;
    run_txn(512, 1, 1);
    req = 2'b00;
    check_eq("t1_grant", gnt_at_exec, 2'b01);
    check_eq("t1_addr", sd_block_address, 32'h10);
    check_eq("t1_op", sd_op_code, 1'b0);
    check_eq("t1_strobes", strobes, 512);
    check_eq("t1_strobe_owner", strobe_or, 2'b01);
    check_eq("t1_rd_data_errs", rd_errs, 0);
    check_eq("t1_count", cnt_at_done, 10'd512);
    check_eq("t1_done", done_seen, 2'b01);
    check_eq("t1_error", err_seen, 2'b00);

    // 2: WRITE from requester 1 with counting data
    req_addr[63:32] = 32'h0000_0BEE; req_op = 2'b10; req = 2'b10;
    run_txn(512, 0, 1);
    req = 2'b00;
    tick(); tick();
    check_eq("t2_grant", gnt_at_exec, 2'b10);
    check_eq("t2_addr", sd_block_address, 32'h0BEE);
    check_eq("t2_op", sd_op_code, 1'b1);
    check_eq("t2_wr_data_errs", wr_errs, 0);
    check_eq("t2_strobes", strobes, 512);
    check_eq("t2_done", done_seen, 2'b10);
    check_eq("t2_error", err_seen, 2'b00);
    check_eq("t2_grant_idle", grant, 2'b00);

    // 3: both requesting, round-robin alternation
    req_op = 2'b00; req = 2'b11;
    for (int n = 0; n < 3; n++) begin
      run_txn(4, 1, 1);
      gseq[n] = gnt_at_exec;
    end
    req = 2'b00;
    check_eq("t3_grant0", gseq[0], 2'b01);
    check_eq("t3_grant1", gseq[1], 2'b10);
    check_eq("t3_grant2", gseq[2], 2'b01);

    // 5: timeout and issue-hold on the short-timeout instance
    req_t = 2'b01; found = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (exec_t) begin found = 1; break; end
    end
    check_eq("t5_exec", {63'd0, found}, 64'd1);
    busy_t = 1'b1; c = 0;
    for (int k = 0; k < 300; k++) begin
      tick(); c++;
      if (done_t != 2'b00) break;
    end
    check_eq("t5_timeout_cycles", c, 100);
    check_eq("t5_done", done_t, 2'b01);
    check_eq("t5_error", error_t, 2'b01);
    req_t = 2'b00; busy_t = 1'b0;
    repeat (3) tick();
    check_eq("t5_recover", {grant_t, exec_t}, 3'b000);
    req_t = 2'b01; found = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (exec_t) begin found = 1; break; end
    end
    check_eq("t5_regrant", grant_t, 2'b01);
    c = 0;
    for (int k = 0; k < 50; k++) begin
      tick(); c++;
      if (done_t != 2'b00) break;
    end
    check_eq("t5_hold_cycles", c, 8);
    check_eq("t5_hold_err", {done_t, error_t}, 4'b0101);
    req_t = 2'b00;

    // 4: busy high after reset holds off the grant
    rst_n = 1'b0; tick();
    sd_busy = 1'b1; req = 2'b01; rst_n = 1'b1;
    held = 1;
    repeat (1000) begin
      tick();
      if (grant != 2'b00 || sd_execute) held = 0;
    end
    check_eq("t4_held_off", {63'd0, held}, 64'd1);
    sd_busy = 1'b0;
    run_txn(4, 1, 1);
    req = 2'b00;
    check_eq("t4_grant", gnt_at_exec, 2'b01);
    check_eq("t4_done", done_seen, 2'b01);

    // 6: reset mid-read, then requester 1 alone is granted
    req_op = 2'b00; req = 2'b01;
    run_txn(200, 1, 0);
    check_eq("t6_strobes", strobes, 200);
    rst_n = 1'b0; sd_busy = 1'b0; req = 2'b00;
    tick();
    check_eq("t6_rst_ctl", {44'd0, grant, byte_strobe, done, error, byte_count, sd_execute, sd_op_code}, 64'd0);
    check_eq("t6_rst_data", {24'd0, sd_block_address, rd_byte}, 64'd0);
    check_eq("t6_no_done", done_seen, 2'b00);
    req = 2'b10; rst_n = 1'b1;
    run_txn(4, 1, 1);
    req = 2'b00;
    check_eq("t6_grant", gnt_at_exec, 2'b10);
    check_eq("t6_done", done_seen, 2'b10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
